// File: rtl/pcpu_pkg.sv
// Shared definitions for the pcpu execute stage: RV32M funct3 encodings,
// the multiply/divide FSM state type and the datapath width.
package pcpu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIN  = 2'd2
    } mdu_state_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/pcpu_mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {high partial, multiplier}; add the multiplicand when the
// current multiplier bit is set, then shift the 65-bit result right.
// Divide: acc[31:0] holds dividend bits shifting out / quotient bits shifting
// in; prem is the 33-bit partial remainder of a restoring division.
module pcpu_mdu_step
    import pcpu_pkg::*;
(
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN:0]     prem,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next,
    output logic [XLEN:0]     prem_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Single shift-add or restoring-subtract step.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        acc_next  = acc;
        prem_next = prem;
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        shifted   = {prem[XLEN-1:0], acc[XLEN-1]};
        diff      = shifted - {1'b0, opnd};
        if (div_mode) begin
            // A clear sign bit on the trial difference means the divisor fits.
            prem_next = diff[XLEN] ? shifted : diff;
            acc_next  = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_next  = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/pcpu_mdu.sv
// Iterative RV32M multiply/divide unit with a req/done handshake.
// Operands are reduced to magnitudes at start, 32 radix-2 steps run in CALC,
// and FIN applies the sign, selects the result half and forces the RISC-V
// divide-by-zero / overflow values.
// Optional build macro PCPU_MDU_EARLY_OUT_EN: trivial operations (divide by
// zero, signed overflow, multiply by zero) skip CALC for a 2-cycle latency.
module pcpu_mdu
    import pcpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] y
);

    mdu_state_t        state;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     prem;
    logic [XLEN-1:0]   opnd;
    logic              neg_q;
    logic              spec_q;
    logic [XLEN-1:0]   spec_val;

    logic              a_sgn, b_sgn, div_op, div_zero, ovf, mul_zero, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag, spec_in;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN:0]     prem_nx;
    logic [XLEN-1:0]   quo, rmd, res;

    // Start-of-operation decode of the raw request operands.
    always_comb begin
        div_op   = is_div_op(op);
        a_sgn    = a[XLEN-1] && (op == MDU_MULH || op == MDU_MULHSU ||
                                 op == MDU_DIV  || op == MDU_REM);
        b_sgn    = b[XLEN-1] && (op == MDU_MULH || op == MDU_DIV || op == MDU_REM);
        a_mag    = a_sgn ? -a : a;
        b_mag    = b_sgn ? -b : b;
        div_zero = div_op && (b == '0);
        ovf      = (op == MDU_DIV || op == MDU_REM) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        mul_zero = !div_op && (a == '0 || b == '0);
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_in   = (op == MDU_REM) ? a_sgn : (a_sgn ^ b_sgn);
        if (div_zero)
            spec_in = op[1] ? a : '1;
        else
            spec_in = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    pcpu_mdu_step u_step (
        .div_mode  (is_div_op(op_q)),
        .acc       (acc),
        .prem      (prem),
        .opnd      (opnd),
        .acc_next  (acc_nx),
        .prem_next (prem_nx)
    );

    // Sign correction and result selection applied in FIN.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg_q ? -prem[XLEN-1:0] : prem[XLEN-1:0];
        case (op_q)
            MDU_MUL:                     res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU,
            MDU_MULHU:                   res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:           res = quo;
            default:                     res = rmd;
        endcase
    end

    // Control FSM with registered busy/done/y; flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset as well so y and the
            // accumulators never expose X after reset.
            state    <= MDU_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            acc      <= '0;
            prem     <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            spec_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            y        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            done <= 1'b0;
            if (flush) begin
                state <= MDU_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    MDU_IDLE: begin
                        if (req) begin
                            op_q     <= op;
                            opnd     <= div_op ? b_mag : a_mag;
                            // A zero multiplier/multiplicand loads a zero
                            // accumulator so the product is 0 without stepping.
                            acc      <= div_op   ? {{XLEN{1'b0}}, a_mag} :
                                        mul_zero ? '0 : {{XLEN{1'b0}}, b_mag};
                            prem     <= '0;
                            neg_q    <= neg_in;
                            spec_q   <= div_zero || ovf;
                            spec_val <= spec_in;
                            cnt      <= '0;
                            busy     <= 1'b1;
`ifdef PCPU_MDU_EARLY_OUT_EN
                            state    <= (div_zero || ovf || mul_zero) ? MDU_FIN : MDU_CALC;
`else
                            state    <= MDU_CALC;
`endif
                        end
                    end
                    MDU_CALC: begin
                        acc  <= acc_nx;
                        prem <= prem_nx;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            state <= MDU_FIN;
                    end
                    MDU_FIN: begin
                        y     <= spec_q ? spec_val : res;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= MDU_IDLE;
                    end
                    default: state <= MDU_IDLE;
                endcase
            end
        end
    end

endmodule
